// File: rtl/somatorio_acc_stream_if.sv
// Handshake bundle for somatorio_acc_stream: sample input stream and result output stream.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface somatorio_acc_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] soma;
  logic             ov;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, soma, ov
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, soma, ov
  );
endinterface

// File: rtl/somatorio_acc_stream.sv
// Streaming accumulator: sums a programmable number of unsigned samples and reports sum + overflow.
// Build option: define SOMATORIO_SAT_EN to saturate soma on overflow instead of wrapping.
module somatorio_acc_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  somatorio_acc_stream_if.slave bus
);

  // Wide enough that (2**CNT_W-1) full-scale samples never wrap.
  localparam int ACC_W = WIDTH + CNT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               beat;
  logic               ov_w;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  assign beat = bus.in_valid & bus.in_ready;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          rem_d   = len;
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d = acc_q + ACC_W'(bus.in_data);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);

  // Result is decoded from acc_q, so it holds in DONE/IDLE and clears when a run starts.
  assign ov_w   = |acc_q[ACC_W-1:WIDTH];
  assign bus.ov = ov_w;
`ifdef SOMATORIO_SAT_EN
  assign bus.soma = ov_w ? {WIDTH{1'b1}} : acc_q[WIDTH-1:0];
`else
  assign bus.soma = acc_q[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_somatorio_acc_stream.sv
// Scoreboard bench for somatorio_acc_stream: expected results are queued when a run starts
// and compared when the result handshake appears. All drive/sample happens on the falling edge.
module tb_somatorio_acc_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             busy;

  somatorio_acc_stream_if #(.WIDTH(WIDTH)) sif ();

  somatorio_acc_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .bus     (sif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] soma;
    logic             ov;
  } res_t;

  res_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic res_t model(input int unsigned sum);
    res_t r;
    r.ov = (sum > 255);
`ifdef SOMATORIO_SAT_EN
    r.soma = r.ov ? 8'hFF : 8'(sum);
`else
    r.soma = 8'(sum);
`endif
    return r;
  endfunction

  task automatic start_run(input int unsigned l);
    start = 1'b1;
    len   = CNT_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input int unsigned d);
    int c = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = WIDTH'(d);
    while (!sif.in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!sif.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_accept: in_ready never rose for data %0d", d);
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  task automatic collect(output res_t got, output bit timed_out);
    int c = 0;
    while (!sif.out_valid && c < 1000) begin
      @(negedge clk);
      c++;
    end
    timed_out = !sif.out_valid;
    got = {sif.soma, sif.ov};
  endtask

  task automatic release_result();
    sif.out_ready = 1'b1;
    @(negedge clk);
    sif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({sif.in_ready, sif.out_valid, busy, sif.soma, sif.ov} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got in_ready=%0b out_valid=%0b busy=%0b soma=%0d ov=%0b, expected all 0",
               sif.in_ready, sif.out_valid, busy, sif.soma, sif.ov);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || sif.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%0b in_ready=%0b, expected 0 0", busy, sif.in_ready);
    end
  endtask

  task automatic test_basic();
    res_t got, exp;
    bit   to;
    start_run(3);
    sb_q.push_back(model(60));
    send_beat(10);
    send_beat(20);
    send_beat(30);
    n_cmp++;
    if (sif.out_valid !== 1'b1 || sif.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_latency: got out_valid=%0b in_ready=%0b one clk after last beat, expected 1 0",
               sif.out_valid, sif.in_ready);
    end
    collect(got, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || got !== exp) begin
      n_bad++;
      $display("FAIL basic_result: got soma=%0d ov=%0b timeout=%0b, expected soma=%0d ov=%0b",
               got.soma, got.ov, to, exp.soma, exp.ov);
    end
    release_result();
    n_cmp++;
    if (busy !== 1'b0 || sif.out_valid !== 1'b0 || sif.soma !== 8'd60) begin
      n_bad++;
      $display("FAIL basic_hold_idle: got busy=%0b out_valid=%0b soma=%0d, expected 0 0 60",
               busy, sif.out_valid, sif.soma);
    end
  endtask

  task automatic test_overflow();
    res_t got, exp;
    bit   to;
    start_run(2);
    n_cmp++;
    if (sif.soma !== 8'd0 || sif.ov !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_clear_on_start: got soma=%0d ov=%0b busy=%0b, expected 0 0 1",
               sif.soma, sif.ov, busy);
    end
    sb_q.push_back(model(300));
    send_beat(200);
    send_beat(100);
    collect(got, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || got !== exp) begin
      n_bad++;
      $display("FAIL ovf_result: got soma=%0d ov=%0b timeout=%0b, expected soma=%0d ov=%0b",
               got.soma, got.ov, to, exp.soma, exp.ov);
    end
    release_result();
  endtask

  task automatic test_zero_len();
    res_t got, exp;
    bit   to;
    sif.in_valid = 1'b1;
    sif.in_data  = 8'd99;
    start_run(0);
    sb_q.push_back(model(0));
    n_cmp++;
    if (sif.out_valid !== 1'b1 || sif.in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_len_done: got out_valid=%0b in_ready=%0b busy=%0b, expected 1 0 1",
               sif.out_valid, sif.in_ready, busy);
    end
    collect(got, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || got !== exp) begin
      n_bad++;
      $display("FAIL zero_len_result: got soma=%0d ov=%0b timeout=%0b, expected soma=%0d ov=%0b",
               got.soma, got.ov, to, exp.soma, exp.ov);
    end
    sif.in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_stall();
    res_t got, exp;
    bit   to;
    int   bad_hold = 0;
    start_run(2);
    len = 8'd5;
    exp = model(90);
    sb_q.push_back(exp);
    send_beat(40);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_gap: got in_ready=%0b out_valid=%0b during in_valid gap, expected 1 0",
               sif.in_ready, sif.out_valid);
    end
    send_beat(50);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      len   = 8'd1;
      if (sif.out_valid !== 1'b1 || {sif.soma, sif.ov} !== exp) bad_hold++;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (bad_hold != 0) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d unstable cycles, expected 0 (soma=%0d ov=%0b)",
               bad_hold, sif.soma, sif.ov);
    end
    collect(got, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || got !== exp) begin
      n_bad++;
      $display("FAIL stall_result: got soma=%0d ov=%0b timeout=%0b, expected soma=%0d ov=%0b",
               got.soma, got.ov, to, exp.soma, exp.ov);
    end
    start = 1'b1;
    release_result();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_start_in_exit: got busy=%0b out_valid=%0b, expected 0 0", busy, sif.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_stay_idle: got busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_reset_midrun();
    res_t got, exp;
    bit   to;
    start_run(3);
    send_beat(7);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({sif.in_ready, sif.out_valid, busy, sif.soma, sif.ov} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: got in_ready=%0b out_valid=%0b busy=%0b soma=%0d ov=%0b, expected all 0",
               sif.in_ready, sif.out_valid, busy, sif.soma, sif.ov);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_run(1);
    sb_q.push_back(model(5));
    send_beat(5);
    collect(got, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || got !== exp) begin
      n_bad++;
      $display("FAIL after_reset_result: got soma=%0d ov=%0b timeout=%0b, expected soma=%0d ov=%0b",
               got.soma, got.ov, to, exp.soma, exp.ov);
    end
    release_result();
  endtask

  task automatic test_long();
    res_t got, exp;
    bit   to;
    start_run(255);
    sb_q.push_back(model(255 * 255));
    for (int i = 0; i < 255; i++) send_beat(255);
    collect(got, to);
    exp = sb_q.pop_front();
    n_cmp++;
    if (to || got !== exp) begin
      n_bad++;
      $display("FAIL long_result: got soma=%0d ov=%0b timeout=%0b, expected soma=%0d ov=%0b",
               got.soma, got.ov, to, exp.soma, exp.ov);
    end
    release_result();
  endtask

  initial begin
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_zero_len();
    test_stall();
    test_reset_midrun();
    test_long();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
